// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings and helpers for the CPU memory path
package cpu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  // Both bits of the IO select field set means the address is in IO space.
  function automatic logic is_io(input logic [31:0] addr, input int sel_hi);
    logic [31:0] mask;
    mask = 32'd3 << (sel_hi - 1);
    return (addr & mask) == mask;
  endfunction

  // Index of the last byte of a transaction; the illegal size 3 behaves as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    logic [1:0] idx;
    case (size)
      SZ_B:    idx = 2'd0;
      SZ_H:    idx = 2'd1;
      SZ_W:    idx = 2'd3;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory bus initiator for fetch and load/store clients
module mem_ctrl
  import cpu_pkg::*;
#(
  parameter int IO_SEL_HI = 17,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              flush_in,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_resp_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_valid,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic              d_resp_valid,
  output logic [31:0]       d_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        last_q, last_d;
  logic              fetch_q, fetch_d;
  logic [1:0]        issue_idx_q, issue_idx_d;
  logic              issue_done_q, issue_done_d;
  logic [1:0]        cap_idx_q, cap_idx_d;
  logic              inflight_q, inflight_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              if_resp_q, if_resp_d;
  logic              d_resp_q, d_resp_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic accept_ok;
  logic io_stall;
  logic issue;

  // Request handshakes and bus drive; the bus is quiet (all zero) outside an issue cycle.
  always_comb begin
    accept_ok = (state_q == IDLE) && rdy_in && !flush_in;
    d_ready   = accept_ok && d_valid;
    if_ready  = accept_ok && !d_valid && if_valid;
    io_stall  = is_io(32'(addr_q), IO_SEL_HI) && io_buffer_full;
    // Reads are not issued in a flush cycle so an aborted IO read never consumes data.
    issue     = ((state_q == RD) && !issue_done_q && rdy_in && !flush_in) ||
                ((state_q == WR) && rdy_in && !io_stall);
    mem_a     = '0;
    mem_wr    = 1'b0;
    mem_dout  = 8'h00;
    if (issue) begin
      mem_a = addr_q + ADDR_W'(issue_idx_q);
      if (state_q == WR) begin
        mem_wr   = 1'b1;
        mem_dout = wdata_q[{issue_idx_q, 3'b000} +: 8];
      end
    end
    if_resp_valid = if_resp_q;
    d_resp_valid  = d_resp_q;
    if_rdata      = if_rdata_q;
    d_rdata       = d_rdata_q;
  end

  // Transaction sequencing: accept, issue bytes in order, capture read bytes one cycle behind.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_d       = last_q;
    fetch_d      = fetch_q;
    issue_idx_d  = issue_idx_q;
    issue_done_d = issue_done_q;
    cap_idx_d    = cap_idx_q;
    inflight_d   = 1'b0;
    rdata_d      = rdata_q;
    if_resp_d    = 1'b0;
    d_resp_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (d_ready || if_ready) begin
          addr_d       = d_ready ? d_addr : if_addr;
          wdata_d      = d_wdata;
          last_d       = d_ready ? last_idx(d_size) : 2'd3;
          fetch_d      = !d_ready;
          issue_idx_d  = 2'd0;
          issue_done_d = 1'b0;
          cap_idx_d    = 2'd0;
          rdata_d      = 32'h0;
          state_d      = (d_ready && d_wr) ? WR : RD;
        end
      end
      RD: begin
        if (flush_in) begin
          state_d = IDLE;
        end else begin
          if (issue) begin
            inflight_d = 1'b1;
            if (issue_idx_q == last_q) begin
              issue_done_d = 1'b1;
            end else begin
              issue_idx_d = issue_idx_q + 2'd1;
            end
          end
          if (inflight_q) begin
            rdata_d[{cap_idx_q, 3'b000} +: 8] = mem_din;
            if (cap_idx_q == last_q) begin
              state_d = IDLE;
              if (fetch_q) begin
                if_resp_d  = 1'b1;
                if_rdata_d = rdata_d;
              end else begin
                d_resp_d  = 1'b1;
                d_rdata_d = rdata_d;
              end
            end else begin
              cap_idx_d = cap_idx_q + 2'd1;
            end
          end
        end
      end
      WR: begin
        if (issue) begin
          if (issue_idx_q == last_q) begin
            state_d  = IDLE;
            d_resp_d = 1'b1;
          end else begin
            issue_idx_d = issue_idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      last_q       <= 2'd0;
      fetch_q      <= 1'b0;
      issue_idx_q  <= 2'd0;
      issue_done_q <= 1'b0;
      cap_idx_q    <= 2'd0;
      inflight_q   <= 1'b0;
      rdata_q      <= 32'h0;
      if_resp_q    <= 1'b0;
      d_resp_q     <= 1'b0;
      if_rdata_q   <= 32'h0;
      d_rdata_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_q       <= last_d;
      fetch_q      <= fetch_d;
      issue_idx_q  <= issue_idx_d;
      issue_done_q <= issue_done_d;
      cap_idx_q    <= cap_idx_d;
      inflight_q   <= inflight_d;
      rdata_q      <= rdata_d;
      if_resp_q    <= if_resp_d;
      d_resp_q     <= d_resp_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized and directed bench for mem_ctrl against a transaction model
module tb_mem_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;
  logic        flush_in = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_ready;
  logic        if_resp_valid;
  logic [31:0] if_rdata;
  logic        d_valid = 1'b0;
  logic        d_wr = 1'b0;
  logic [1:0]  d_size = 2'd0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_ready;
  logic        d_resp_valid;
  logic [31:0] d_rdata;

  mem_ctrl dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .flush_in(flush_in),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .d_valid(d_valid), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_resp_valid(d_resp_valid),
    .d_rdata(d_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Memory seen by the bus responder (written by the DUT) and the model's own memory.
  logic [7:0] env_mem [logic [31:0]];
  logic [7:0] model_mem [logic [31:0]];

  // Transaction-level model state.
  bit          m_busy = 0, m_write = 0, m_fetch = 0, m_prev = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_word = 0;
  int          m_n = 0, m_issued = 0, m_captured = 0;
  bit          m_pend_if = 0, m_pend_d = 0, m_pend_load = 0;
  logic [31:0] m_if_word = 0, m_d_word = 0;

  // Observations of the last simulated cycle.
  int          if_resp_n = 0, d_resp_n = 0, last_if_resp = 0, last_d_resp = 0;
  logic        obs_if_ready, obs_d_ready, obs_mem_wr;
  logic [31:0] obs_mem_a, obs_if_rdata, obs_d_rdata;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] env_byte(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] model_byte(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] env_word(input logic [31:0] a);
    return {env_byte(a + 32'd3), env_byte(a + 32'd2), env_byte(a + 32'd1), env_byte(a)};
  endfunction

  function automatic bit io_addr(input logic [31:0] a);
    return ((a >> 16) & 32'd3) == 32'd3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    env_mem[a] = b;
    model_mem[a] = b;
  endtask

  // One bus cycle: compare at the falling edge, advance the model, then answer the bus.
  task automatic cycle();
    logic        e_if_rdy, e_d_rdy, iss;
    logic [31:0] e_a;
    logic [7:0]  e_dout, nd;
    @(negedge clk);
    e_d_rdy  = !m_busy && rdy_in && !flush_in && d_valid;
    e_if_rdy = !m_busy && rdy_in && !flush_in && !d_valid && if_valid;
    iss = 1'b0;
    if (m_busy) begin
      if (m_write) iss = rdy_in && !(io_addr(m_addr) && io_buffer_full);
      else         iss = rdy_in && !flush_in && (m_issued < m_n);
    end
    e_a    = iss ? m_addr + 32'(m_issued) : 32'h0;
    e_dout = (iss && m_write) ? 8'(m_wdata >> (8 * m_issued)) : 8'h00;
    chk("d_ready", {31'h0, d_ready}, {31'h0, e_d_rdy});
    chk("if_ready", {31'h0, if_ready}, {31'h0, e_if_rdy});
    chk("mem_a", mem_a, e_a);
    chk("mem_wr", {31'h0, mem_wr}, {31'h0, iss && m_write});
    if (iss && m_write) chk("mem_dout", {24'h0, mem_dout}, {24'h0, e_dout});
    chk("if_resp_valid", {31'h0, if_resp_valid}, {31'h0, m_pend_if});
    chk("d_resp_valid", {31'h0, d_resp_valid}, {31'h0, m_pend_d});
    if (m_pend_if) chk("if_rdata", if_rdata, m_if_word);
    if (m_pend_load) chk("d_rdata", d_rdata, m_d_word);
    obs_if_ready = if_ready; obs_d_ready = d_ready; obs_mem_wr = mem_wr;
    obs_mem_a = mem_a; obs_if_rdata = if_rdata; obs_d_rdata = d_rdata;
    if (if_resp_valid) begin if_resp_n++; last_if_resp = cyc; end
    if (d_resp_valid) begin d_resp_n++; last_d_resp = cyc; end
    if (mem_wr) env_mem[mem_a] = mem_dout;
    nd = env_byte(mem_a);
    // model advance across the coming rising edge
    if (iss && m_write) model_mem[e_a] = e_dout;
    m_pend_if = 0; m_pend_d = 0; m_pend_load = 0;
    if (rst_in) begin
      m_busy = 0; m_prev = 0;
    end else if (m_busy) begin
      if (!m_write) begin
        if (flush_in) begin
          m_busy = 0; m_prev = 0;
        end else begin
          if (m_prev) begin
            m_word = m_word | (32'(model_byte(m_addr + 32'(m_captured))) << (8 * m_captured));
            m_captured++;
            if (m_captured == m_n) begin
              m_busy = 0;
              if (m_fetch) begin m_pend_if = 1; m_if_word = m_word; end
              else begin m_pend_d = 1; m_pend_load = 1; m_d_word = m_word; end
            end
          end
          m_prev = iss;
          if (iss) m_issued++;
        end
      end else if (iss) begin
        m_issued++;
        if (m_issued == m_n) begin m_busy = 0; m_pend_d = 1; end
      end
    end else if (e_d_rdy || e_if_rdy) begin
      m_busy = 1; m_prev = 0; m_issued = 0; m_captured = 0; m_word = 0;
      m_fetch = e_if_rdy;
      m_write = e_d_rdy && d_wr;
      m_addr  = e_d_rdy ? d_addr : if_addr;
      m_wdata = d_wdata;
      m_n     = e_if_rdy ? 4 : (d_size == 2'd0 ? 1 : (d_size == 2'd1 ? 2 : 4));
    end
    cyc++;
    @(posedge clk);
    #1;
    mem_din = nd;
  endtask

  task automatic wait_resp(input bit want_if, input int budget, input string name);
    int start;
    int n;
    bit got;
    start = want_if ? if_resp_n : d_resp_n;
    got = 0;
    n = 0;
    while (!got && n < budget) begin
      cycle();
      n++;
      got = want_if ? (if_resp_n > start) : (d_resp_n > start);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s no response within %0d cycles, required one", name, budget);
    end
  endtask

  task automatic idle_inputs();
    rst_in = 0; rdy_in = 1; flush_in = 0; io_buffer_full = 0;
    if_valid = 0; d_valid = 0; d_wr = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0:       a = 32'h1000 + 32'($urandom_range(0, 31));
      1:       a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      2:       a = IO_BASE + 32'($urandom_range(0, 7));
      default: a = 32'($urandom);
    endcase
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int n0;
    @(posedge clk);
    #1;
    cycle();
    idle_inputs();
    cycle();
    // reset state
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
    chk("rst_resp", {30'h0, if_resp_valid, d_resp_valid}, 32'h0);
    chk("rst_rdata", if_rdata | d_rdata, 32'h0);

    // fetch of a known word
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    if_valid = 1; if_addr = 32'h100; a = cyc;
    cycle();
    if_valid = 0;
    wait_resp(1, 12, "fetch_resp");
    chk("fetch_latency", 32'(last_if_resp - a), 32'd6);
    chk("fetch_word", obs_if_rdata, 32'h0000_0513);

    // store wins arbitration over a simultaneous fetch
    d_valid = 1; if_valid = 1; d_wr = 1; d_size = 2'd2;
    d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; a = cyc;
    cycle();
    chk("arb_d_ready", {31'h0, obs_d_ready}, 32'd1);
    chk("arb_if_ready", {31'h0, obs_if_ready}, 32'd0);
    d_valid = 0;
    wait_resp(0, 12, "store_resp");
    chk("store_latency", 32'(last_d_resp - a), 32'd5);
    chk("fetch_after_store", {31'h0, obs_if_ready}, 32'd1);
    chk("store_bytes", env_word(32'h200), 32'hDEAD_BEEF);
    if_valid = 0;
    wait_resp(1, 12, "fetch2_resp");

    // IO byte store held off by a full UART buffer
    d_valid = 1; d_wr = 1; d_size = 2'd0; d_addr = IO_BASE;
    d_wdata = 32'h0000_00A5; io_buffer_full = 1; a = cyc;
    cycle();
    d_valid = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("io_stall_wr", {31'h0, obs_mem_wr}, 32'd0);
    end
    io_buffer_full = 0;
    wait_resp(0, 8, "io_store_resp");
    chk("io_latency", 32'(last_d_resp - a), 32'd5);
    chk("io_byte", {24'h0, env_byte(IO_BASE)}, 32'h0000_00A5);

    // halfword load with the bus lent away for one cycle
    preload(32'h1FF, 8'h34);
    d_valid = 1; d_wr = 0; d_size = 2'd1; d_addr = 32'h1FF; a = cyc;
    cycle();
    d_valid = 0;
    cycle();
    rdy_in = 0;
    cycle();
    rdy_in = 1;
    wait_resp(0, 10, "half_resp");
    chk("half_latency", 32'(last_d_resp - a), 32'd5);
    chk("half_data", obs_d_rdata, 32'h0000_EF34);

    // flush aborts a fetch
    n0 = if_resp_n;
    if_valid = 1; if_addr = 32'h100;
    cycle();
    if_valid = 0;
    cycle();
    cycle();
    flush_in = 1;
    cycle();
    flush_in = 0; if_valid = 1;
    cycle();
    chk("flush_idle_ready", {31'h0, obs_if_ready}, 32'd1);
    chk("flush_no_resp", 32'(if_resp_n - n0), 32'd0);
    if_valid = 0;
    wait_resp(1, 12, "post_flush_fetch");

    // flush does not abort a store
    d_valid = 1; d_wr = 1; d_size = 2'd2; d_addr = 32'h300; d_wdata = 32'h1122_3344; a = cyc;
    cycle();
    d_valid = 0; flush_in = 1;
    cycle();
    cycle();
    flush_in = 0;
    wait_resp(0, 10, "flush_store_resp");
    chk("flush_store_latency", 32'(last_d_resp - a), 32'd5);
    chk("flush_store_bytes", env_word(32'h300), 32'h1122_3344);

    // reset in the middle of a store
    d_valid = 1; d_wr = 1; d_size = 2'd2; d_addr = 32'h400; d_wdata = 32'hCAFE_F00D;
    cycle();
    d_valid = 0;
    cycle();
    rst_in = 1;
    cycle();
    rst_in = 0;
    n0 = d_resp_n;
    cycle();
    chk("rst_mid_wr", {31'h0, obs_mem_wr}, 32'd0);
    chk("rst_mid_a", obs_mem_a, 32'h0);
    repeat (6) cycle();
    chk("rst_no_resp", 32'(d_resp_n - n0), 32'd0);
    if_valid = 1; if_addr = 32'h400;
    cycle();
    chk("rst_then_accept", {31'h0, obs_if_ready}, 32'd1);
    if_valid = 0;
    wait_resp(1, 12, "post_rst_fetch");

    // randomized traffic, including address wrap, IO space, flushes, stalls and resets
    for (int i = 0; i < 3000; i++) begin
      rst_in         = ($urandom_range(0, 199) == 0);
      flush_in       = ($urandom_range(0, 19) == 0);
      rdy_in         = ($urandom_range(0, 9) != 0);
      io_buffer_full = ($urandom_range(0, 2) == 0);
      d_valid        = ($urandom_range(0, 9) < 4);
      if_valid       = ($urandom_range(0, 1) == 1);
      d_wr           = ($urandom_range(0, 1) == 1);
      d_size         = 2'($urandom_range(0, 3));
      d_addr         = rand_addr();
      if_addr        = rand_addr();
      d_wdata        = 32'($urandom);
      cycle();
    end
    idle_inputs();
    repeat (12) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
